param_serializer: RTL and testbench
===================================

// Module: param_serializer
// PURPOSE
//  Parametrised parallel-to-serial converter; next generation of the UART TX serializer.
//  Generic DATA_W, selectable bit order, one-entry holding buffer with valid/ready handshake.
//  Back-to-back words with no idle bit between them; one-cycle SER_DONE pulse per word.
//  Sits between the TX FIFO/ALU result path and the TX framing FSM; SER_EN is the per-bit tick.
// PARAMETERS
//  DATA_W      8   word width in bits, >= 1
//  MSB_FIRST   0   0: LSB transmitted first; 1: MSB first
//  IDLE_LEVEL  1'b1 SER_DATA level when no word is being shifted
// PORTS
//  CLK         in   1        single clock; all state changes on posedge
//  RST         in   1        reset: synchronous, active-high
//  P_DATA      in   DATA_W   parallel word, sampled when DATA_VALID && DATA_READY
//  DATA_VALID  in   1        producer has a word; must hold P_DATA until accepted
//  DATA_READY  out  1        = !hold_full (combinational from a register)
//  SER_EN      in   1        bit tick; SER_DATA changes only on cycles with SER_EN=1
//  SER_DATA    out  1        registered serial output
//  SER_DONE    out  1        registered; 1-cycle pulse when final bit of a word is driven
//  BUSY        out  1        = (state != IDLE) || hold_full
// BEHAVIOUR
//  Reset: state=IDLE, hold_full=0, count=0, shift_reg=0, SER_DATA=IDLE_LEVEL, SER_DONE=0.
//  Reset mid-word: the word and any held word are discarded; no SER_DONE.
//  Accept: DATA_VALID && DATA_READY -> hold_reg<=P_DATA, hold_full<=1. Valid while full: ignored.
//  FSM IDLE: hold_full -> next edge shift_reg<=hold_reg, hold_full<=0, count<=0, state<=SHIFT.
//   No bit is emitted on this edge even if SER_EN=1.
//   SER_EN in IDLE -> SER_DATA<=IDLE_LEVEL. Without SER_EN, SER_DATA holds its last value.
//  FSM SHIFT, SER_EN=1: SER_DATA<=current bit (shift_reg[0], or [DATA_W-1] if MSB_FIRST).
//   Shift toward that end. count<=count+1.
//  Last bit (count==DATA_W-1 && SER_EN): SER_DONE<=1 on the same edge. Then:
//   hold_full -> reload shift_reg from hold_reg, count<=0, stay SHIFT, hold_full<=0.
//   Gapless: the next word's bit 0 is driven on the following SER_EN.
//   else -> IDLE. The last bit holds on SER_DATA until the next SER_EN drives IDLE_LEVEL.
//  SER_DONE is 0 on every other cycle; exactly one pulse per word.
//  Accept while SHIFT: allowed whenever hold empty.
//   Accept on the same edge as a last-bit reload is impossible, because ready=0 then.
//  SER_EN=0 in SHIFT: full hold; state, count and outputs unchanged.
//  count width = max(1,$clog2(DATA_W)). DATA_W=1: every SER_EN in SHIFT is a last bit.
//  Latency: accept edge -> +1 edge load -> first bit on first SER_EN edge after load.
// CONFIGURATION
//  Macro SER_PARITY_EN.
//  Defined:
//   adds input PAR_TYPE (1 bit; 0 even, 1 odd) and state PARITY after SHIFT.
//   Parity is computed from the word at load and registered.
//   Last data bit goes to PARITY, not IDLE/reload; SER_DONE does not fire on it.
//   On the next SER_EN, SER_DATA<=parity bit and SER_DONE pulses.
//   Reload/IDLE decision then as above.
//   PAR_TYPE is sampled at load time.
//  Undefined: no PAR_TYPE port, no PARITY state; behaviour exactly as above.
// STRUCTURE
//  Package ser_pkg:
//   typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_PARITY} ser_state_e
//   function calc_parity(data, par_type), parametrised via DATA_W argument width
//  Sub-module ser_hold_buf: one-entry valid/ready register.
//   Ports: CLK, RST, din, in_valid, in_ready, dout, full, pop.
//   The FSM asserts pop on load/reload.
// TESTING
//  1 Reset then P_DATA=8'hA5, valid, SER_EN every 4 clk.
//    -> SER_DATA=1,0,1,0,0,1,0,1; one SER_DONE pulse with bit 7; then IDLE_LEVEL.
//  2 MSB_FIRST=1, 8'hA5 -> bits 1,0,1,0,0,1,0,1 in MSB-first order; same SER_DONE timing.
//  3 Push 8'h0F during shift, then 8'hF0 also while shifting.
//    -> 0F sent gaplessly after first word; ready=0 until reload; F0 valid held, accepted after.
//  4 RST=1 at bit 3 with a held word -> next cycle SER_DATA=IDLE_LEVEL, BUSY=0, no SER_DONE.
//    Fresh word afterwards is sent intact.
//  5 SER_EN held low 10 clk mid-word -> outputs frozen; resumes at correct bit; count unaffected.
//  6 SER_PARITY_EN, PAR_TYPE=0, 8'h07 -> 8 data bits, then parity 1.
//    SER_DONE only with parity bit. PAR_TYPE=1 -> parity 0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and helpers for the parametrised serializer.
// Optional parity stage is enabled by defining SER_PARITY_EN.
package ser_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_SHIFT  = 2'd1,
        SER_PARITY = 2'd2
    } ser_state_e;

    // Callers zero-extend their word; zero padding leaves the parity unchanged.
    localparam int unsigned SER_PAR_MAX_W = 4096;

    function automatic logic calc_parity(
        input logic [SER_PAR_MAX_W-1:0] data,
        input logic                     par_type
    );
        return (^data) ^ par_type;
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register with valid/ready on the write side
// and a pop strobe from the serializer FSM on the read side.
module ser_hold_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] din,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    input  logic              pop
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (pop) begin
            full_d = 1'b0;
        end
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !full_q;
    assign dout     = data_q;
    assign full     = full_q;

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with gapless back-to-back words.
// Define SER_PARITY_EN to append a parity bit (adds PAR_TYPE port).
module param_serializer
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    output logic              DATA_READY,
    input  logic              SER_EN,
`ifdef SER_PARITY_EN
    input  logic              PAR_TYPE,
`endif
    output logic              SER_DATA,
    output logic              SER_DONE,
    output logic              BUSY
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic              hold_ready;
    logic              pop;
    logic              load_word;
    logic              cur_bit;
    logic              last_bit;
    logic [DATA_W-1:0] shifted;

`ifdef SER_PARITY_EN
    logic par_q, par_d;
`endif

    ser_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold (
        .CLK      (CLK),
        .RST      (RST),
        .din      (P_DATA),
        .in_valid (DATA_VALID),
        .in_ready (hold_ready),
        .dout     (hold_data),
        .full     (hold_full),
        .pop      (pop)
    );

    assign cur_bit  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
    assign shifted  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
    assign last_bit = (count_q == LAST_CNT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SER_IDLE;
            count_q <= '0;
            shift_q <= '0;
            ser_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE: begin
                if (hold_full) begin
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (SER_EN && last_bit) begin
`ifdef SER_PARITY_EN
                    state_d = SER_PARITY;
`else
                    state_d = hold_full ? SER_SHIFT : SER_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            SER_PARITY: begin
                if (SER_EN) begin
                    state_d = hold_full ? SER_SHIFT : SER_IDLE;
                end
            end
`endif
            default: state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        shift_d   = shift_q;
        ser_d     = ser_q;
        done_d    = 1'b0;
        load_word = 1'b0;
        pop       = 1'b0;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            SER_IDLE: begin
                if (SER_EN) begin
                    ser_d = IDLE_LEVEL;
                end
                load_word = hold_full;
            end
            SER_SHIFT: begin
                if (SER_EN) begin
                    ser_d   = cur_bit;
                    shift_d = shifted;
                    count_d = count_q + CNT_W'(1);
                    if (last_bit) begin
                        count_d = '0;
`ifdef SER_PARITY_EN
                        load_word = 1'b0;
`else
                        done_d    = 1'b1;
                        load_word = hold_full;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            SER_PARITY: begin
                if (SER_EN) begin
                    ser_d     = par_q;
                    done_d    = 1'b1;
                    load_word = hold_full;
                end
            end
`endif
            default: begin
                count_d = '0;
            end
        endcase
        // Load from IDLE and gapless reload share one path; no bit is emitted by it.
        if (load_word) begin
            shift_d = hold_data;
            count_d = '0;
            pop     = 1'b1;
`ifdef SER_PARITY_EN
            par_d   = calc_parity(SER_PAR_MAX_W'(hold_data), PAR_TYPE);
`endif
        end
    end

    assign SER_DATA   = ser_q;
    assign SER_DONE   = done_q;
    assign DATA_READY = hold_ready;
    assign BUSY       = (state_q != SER_IDLE) || hold_full;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: LSB-first and MSB-first instances share
// randomized stimulus; a word/bit-position queue model predicts every cycle.
module tb_param_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       ser_en;
    logic       par_type;
    logic [7:0] pdata;
    logic [1:0] ready, sdata, sdone, busy;

    always #5 clk = ~clk;

    param_serializer #(
        .DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
    ) u_lsb (
        .CLK(clk), .RST(rst), .P_DATA(pdata), .DATA_VALID(valid),
        .DATA_READY(ready[0]), .SER_EN(ser_en),
`ifdef SER_PARITY_EN
        .PAR_TYPE(par_type),
`endif
        .SER_DATA(sdata[0]), .SER_DONE(sdone[0]), .BUSY(busy[0])
    );

    param_serializer #(
        .DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
    ) u_msb (
        .CLK(clk), .RST(rst), .P_DATA(pdata), .DATA_VALID(valid),
        .DATA_READY(ready[1]), .SER_EN(ser_en),
`ifdef SER_PARITY_EN
        .PAR_TYPE(par_type),
`endif
        .SER_DATA(sdata[1]), .SER_DONE(sdone[1]), .BUSY(busy[1])
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] cur_w[2];
    logic [7:0] hold_w[2];
    logic [7:0] rec[2];
    bit         hold_v[2];
    bit         cur_p[2];
    int         left[2];
    int         pos[2];
    logic       exp_d[2];
    bit         accepted;
    int         done_m = 0;
    int         done_dut = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic word_bit(input int d, input logic [7:0] w,
                                      input int p);
        return (d == 1) ? w[7-p] : w[p];
    endfunction

    task automatic load(input int d);
        cur_w[d]  = hold_w[d];
        cur_p[d]  = (^hold_w[d]) ^ par_type;
        pos[d]    = 0;
        left[d]   = NB;
        hold_v[d] = 1'b0;
    endtask

    // Called #1 after an edge; inputs still hold their pre-edge values.
    task automatic model_step(input int d);
        bit acc;
        bit dn;
        acc = 1'b0;
        dn  = 1'b0;
        if (rst) begin
            hold_v[d] = 1'b0;
            left[d]   = 0;
            exp_d[d]  = 1'b1;
        end else begin
            acc = valid && !hold_v[d];
            if (left[d] == 0) begin
                if (ser_en) exp_d[d] = 1'b1;
                if (hold_v[d]) load(d);
            end else if (ser_en) begin
                if (pos[d] < 8) begin
                    exp_d[d] = word_bit(d, cur_w[d], pos[d]);
                    rec[d][(d == 1) ? 7 - pos[d] : pos[d]] = sdata[d];
                end else begin
                    exp_d[d] = cur_p[d];
                end
                pos[d]++;
                left[d]--;
                if (left[d] == 0) begin
                    dn = 1'b1;
                    if (hold_v[d]) load(d);
                end
            end
            if (acc) begin
                hold_w[d] = pdata;
                hold_v[d] = 1'b1;
            end
        end
        if (d == 0) begin
            accepted = acc;
            if (dn) done_m++;
        end
        check($sformatf("ser_data%0d", d), 32'(sdata[d]), 32'(exp_d[d]));
        check($sformatf("ser_done%0d", d), 32'(sdone[d]), 32'(dn));
        check($sformatf("ready%0d", d), 32'(ready[d]), 32'(!hold_v[d]));
        check($sformatf("busy%0d", d), 32'(busy[d]),
              32'((left[d] != 0) || hold_v[d]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        if (sdone[0]) done_dut++;
    endtask

    task automatic drive(input int vprob, input int period, input int cyc,
                         input bit freeze);
        ser_en = !freeze && ((cyc % period) == 0);
        if (accepted) valid = 1'b0;
        if (!valid && ($urandom_range(0, 99) < vprob)) begin
            valid = 1'b1;
            pdata = 8'($urandom);
        end
        par_type = 1'($urandom);
    endtask

    initial begin
        int period;
        int vprob;
        int rst_at;
        int frz_at;
        rst = 1'b1;
        valid = 1'b0;
        ser_en = 1'b0;
        pdata = 8'h00;
        par_type = 1'b0;
        accepted = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hold_v[d] = 1'b0;
            left[d] = 0;
            pos[d] = 0;
            exp_d[d] = 1'b1;
            rec[d] = 8'h00;
            cur_w[d] = 8'h00;
            hold_w[d] = 8'h00;
            cur_p[d] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        done_dut = 0;
        done_m = 0;

        valid = 1'b1;
        pdata = 8'hA5;
        for (int c = 0; c < 60; c++) begin
            step();
            ser_en = ((c % 4) == 3);
            if (accepted) valid = 1'b0;
        end
        check("a5_lsb_word", 32'(rec[0]), 32'hA5);
        check("a5_msb_word", 32'(rec[1]), 32'hA5);
        check("a5_done_cnt", 32'(done_dut), 32'd1);

        for (int ph = 0; ph < 12; ph++) begin
            period = $urandom_range(1, 4);
            vprob  = ((ph % 3) == 0) ? 100 : $urandom_range(10, 90);
            rst_at = ((ph % 4) == 2) ? $urandom_range(20, 200) : -1;
            frz_at = $urandom_range(10, 200);
            for (int c = 0; c < 250; c++) begin
                rst = (c == rst_at);
                drive(vprob, period, c, (c >= frz_at) && (c < frz_at + 10));
                step();
            end
        end

        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive(0, 1, c, 1'b0);
            step();
        end
        check("done_total", 32'(done_dut), 32'(done_m));
        check("idle_end", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
